spike_event_pipe_out: RTL and testbench

Host-bound spike-event transmitter for the pipe-out endpoint: captures motoneuron spike IDs and simulation-tick boundaries, packs them into 16-bit words, buffers them in a block-RAM FIFO and serves them to an okBTPipeOut endpoint. It is the readback counterpart of the pipe-in waveform loader: the loader pushes host data into the fabric, and this block streams spike rasters back to the host. It sits between the neuron pool's `spike`/`spkid` outputs and the okBTPipeOut `ep_read`/`ep_datain`/`ep_ready` signals. All inputs are already synchronous to `clk`, which is ti_clk at top level.

---
 rtl/spike_event_pipe_out.sv | 135 +++++++++++++
 tb/tb_spike_event_pipe_out.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_pipe_out.sv
// Spike/tick event packer feeding an okBTPipeOut endpoint through a block-RAM FIFO.
// Spike words {0,id[14:0]} take priority; tick markers {1,tick_cnt} wait in a one-deep pending slot.
module spike_event_pipe_out #(
  parameter int ADDR_W      = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              spike,
  input  logic [15:0]       spike_id,
  input  logic              tick,
  input  logic              ep_read,
  output logic [15:0]       ep_datain,
  output logic              ep_ready,
  output logic [ADDR_W:0]   fill_level,
  output logic              overflow,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       underrun_cnt
);

  localparam int FW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL  = FW'(DEPTH);
  localparam logic [ADDR_W:0] BLOCK_LVL = FW'(BLOCK_WORDS);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t state, state_next;

  logic [14:0]       tick_cnt;
  logic              spike_acc, tick_acc, full;
  logic              wr_spike, wr_marker, wr_en, pop, drop, underrun;
  logic [15:0]       wr_data;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   fill_next, ram_cnt;
  logic [15:0]       mem [DEPTH];
  logic [15:0]       ram_q;
  logic              q_valid, out_valid, q_take, rd_en;

  assign spike_acc = enable & spike;
  assign tick_acc  = enable & tick;
  assign full      = (fill_level == FULL_LVL);
  assign wr_spike  = spike_acc & ~full;
  assign drop      = spike_acc & full;
  assign wr_en     = wr_spike | wr_marker;
  assign wr_data   = wr_spike ? {1'b0, spike_id[14:0]} : {1'b1, tick_cnt};

  // A read that lands while a freshly written word is still in the prefetch
  // pipeline (fill_level != 0 but nothing presented) is neither a pop nor an underrun.
  assign pop      = ep_read & out_valid;
  assign underrun = ep_read & (fill_level == '0);

  // Two-stage prefetch: ram_q (BRAM read register) feeds the ep_datain register.
  assign ram_cnt = fill_level - FW'(out_valid) - FW'(q_valid);
  assign q_take  = q_valid & (~out_valid | pop);
  assign rd_en   = (~q_valid | q_take) & (ram_cnt != '0);

  always_comb begin
    // NOTE: default first so no path through the case leaves fill_next unassigned (no latch).
    fill_next = fill_level;
    case ({wr_en, pop})
      2'b10:   fill_next = fill_level + FW'(1);
      2'b01:   fill_next = fill_level - FW'(1);
      default: fill_next = fill_level;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick_acc) state_next = PENDING;
      PENDING: if (wr_marker && !tick_acc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_marker = (state == PENDING) && !spike_acc && !full;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level   <= '0;
      ep_ready     <= 1'b0;
      tick_cnt     <= '0;
      overflow     <= 1'b0;
      drop_cnt     <= '0;
      underrun_cnt <= '0;
      q_valid      <= 1'b0;
      out_valid    <= 1'b0;
      ep_datain    <= 16'hFFFF;
    end else begin
      fill_level <= fill_next;
      ep_ready   <= (fill_next >= BLOCK_LVL);
      if (wr_en)    wr_ptr   <= wr_ptr + ADDR_W'(1);
      if (tick_acc) tick_cnt <= tick_cnt + 15'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      if (underrun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;

      if (rd_en) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        q_valid <= 1'b1;
      end else if (q_take) begin
        q_valid <= 1'b0;
      end

      if (!out_valid || pop) begin
        out_valid <= q_valid;
        ep_datain <= q_valid ? ram_q : 16'hFFFF;
      end
    end
  end

  // NOTE: the RAM array and its read register are deliberately not reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
    if (rd_en) ram_q <= mem[rd_ptr];
  end

endmodule

// File: tb/tb_spike_event_pipe_out.sv
// Directed bench for spike_event_pipe_out, built with a 16-word FIFO and 8-word blocks.
module tb_spike_event_pipe_out;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        spike;
  logic [15:0] spike_id;
  logic        tick;
  logic        ep_read;
  logic [15:0] ep_datain;
  logic        ep_ready;
  logic [4:0]  fill_level;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [15:0] underrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  spike_event_pipe_out #(.ADDR_W(4), .BLOCK_WORDS(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .spike        (spike),
    .spike_id     (spike_id),
    .tick         (tick),
    .ep_read      (ep_read),
    .ep_datain    (ep_datain),
    .ep_ready     (ep_ready),
    .fill_level   (fill_level),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; enable = 1'b1; spike = 1'b0; spike_id = '0; tick = 1'b0; ep_read = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; spike = 1'b0; spike_id = '0; tick = 1'b0; ep_read = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    if (fill_level !== 5'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
    n_checks++;
    if (ep_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ep_ready); end
    n_checks++;
    if (ep_datain !== 16'hFFFF) begin n_fail++; $display("FAIL reset_datain: got %h want ffff", ep_datain); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_checks++;
    if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    n_checks++;
    if (underrun_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_underrun: got %0d want 0", underrun_cnt); end
    n_checks++;
  endtask

  task automatic test_basic();
    logic [15:0] exp [4];
    exp[0] = 16'h0005; exp[1] = 16'h0006; exp[2] = 16'h0007; exp[3] = 16'h8001;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      spike = 1'b1; spike_id = 16'(5 + i);
      step();
      spike = 1'b0;
      step();
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    step(); step(); step();
    if (fill_level !== 5'd4) begin n_fail++; $display("FAIL basic_fill: got %0d want 4", fill_level); end
    n_checks++;
    if (ep_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready: got %b want 0", ep_ready); end
    n_checks++;
    for (int i = 0; i < 4; i++) begin
      if (ep_datain !== exp[i]) begin n_fail++; $display("FAIL basic_word%0d: got %h want %h", i, ep_datain, exp[i]); end
      n_checks++;
      ep_read = 1'b1;
      step();
      ep_read = 1'b0;
    end
    if (fill_level !== 5'd0) begin n_fail++; $display("FAIL basic_drained: got %0d want 0", fill_level); end
    n_checks++;
  endtask

  task automatic test_same_cycle();
    apply_reset();
    spike = 1'b1; spike_id = 16'h0012; tick = 1'b1;
    step();
    spike = 1'b0; tick = 1'b0;
    if (fill_level !== 5'd1) begin n_fail++; $display("FAIL same_fill_n: got %0d want 1", fill_level); end
    n_checks++;
    step();
    if (fill_level !== 5'd2) begin n_fail++; $display("FAIL same_fill_n1: got %0d want 2", fill_level); end
    n_checks++;
    step(); step();
    if (ep_datain !== 16'h0012) begin n_fail++; $display("FAIL same_spike_word: got %h want 0012", ep_datain); end
    n_checks++;
    ep_read = 1'b1;
    step();
    ep_read = 1'b0;
    if (ep_datain !== 16'h8001) begin n_fail++; $display("FAIL same_marker_word: got %h want 8001", ep_datain); end
    n_checks++;
  endtask

  task automatic test_enable();
    apply_reset();
    enable = 1'b0; spike = 1'b1; spike_id = 16'h0033; tick = 1'b1;
    step();
    spike = 1'b0; tick = 1'b0;
    step(); step();
    if (fill_level !== 5'd0) begin n_fail++; $display("FAIL enable_ignored: got %0d want 0", fill_level); end
    n_checks++;
    enable = 1'b1; spike = 1'b1; spike_id = 16'hFFFF;
    step();
    spike = 1'b0;
    step(); step();
    if (ep_datain !== 16'h7FFF) begin n_fail++; $display("FAIL enable_id_mask: got %h want 7fff", ep_datain); end
    n_checks++;
    ep_read = 1'b1;
    step();
    ep_read = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step(); step(); step();
    if (ep_datain !== 16'h8001) begin n_fail++; $display("FAIL enable_tick_cnt: got %h want 8001", ep_datain); end
    n_checks++;
  endtask

  task automatic test_full();
    logic [15:0] exp;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      spike = 1'b1; spike_id = 16'(i);
      step();
    end
    spike = 1'b0;
    step();
    if (fill_level !== 5'd16) begin n_fail++; $display("FAIL full_fill: got %0d want 16", fill_level); end
    n_checks++;
    if (ep_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready: got %b want 1", ep_ready); end
    n_checks++;
    if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL full_drop: got %0d want 4", drop_cnt); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_overflow: got %b want 1", overflow); end
    n_checks++;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step(); step();
    if (fill_level !== 5'd16) begin n_fail++; $display("FAIL full_marker_held: got %0d want 16", fill_level); end
    n_checks++;
    ep_read = 1'b1;
    for (int k = 0; k < 17; k++) begin
      exp = (k < 16) ? 16'(k) : 16'h8001;
      if (ep_datain !== exp) begin n_fail++; $display("FAIL full_word%0d: got %h want %h", k, ep_datain, exp); end
      n_checks++;
      step();
    end
    ep_read = 1'b0;
    if (fill_level !== 5'd0) begin n_fail++; $display("FAIL full_drained: got %0d want 0", fill_level); end
    n_checks++;
    if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL full_marker_not_dropped: got %0d want 4", drop_cnt); end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      spike = 1'b1; spike_id = 16'h0100 + 16'(i);
      step();
    end
    spike = 1'b0;
    step(); step(); step();
    if (fill_level !== 5'd8) begin n_fail++; $display("FAIL b2b_fill: got %0d want 8", fill_level); end
    n_checks++;
    if (ep_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", ep_ready); end
    n_checks++;
    ep_read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (ep_datain !== 16'h0100 + 16'(i)) begin
        n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, ep_datain, 16'h0100 + 16'(i));
      end
      n_checks++;
      step();
      if (i == 0) begin
        if (ep_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_fall: got %b want 0", ep_ready); end
        n_checks++;
      end
    end
    if (ep_datain !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_empty_word: got %h want ffff", ep_datain); end
    n_checks++;
    step();
    ep_read = 1'b0;
    if (underrun_cnt !== 16'd1) begin n_fail++; $display("FAIL b2b_underrun: got %0d want 1", underrun_cnt); end
    n_checks++;
    if (fill_level !== 5'd0) begin n_fail++; $display("FAIL b2b_fill_end: got %0d want 0", fill_level); end
    n_checks++;
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 32766; i++) begin
      tick = 1'b1;
      ep_read = (fill_level != 5'd0);
      step();
    end
    tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ep_read = (fill_level != 5'd0);
      step();
    end
    ep_read = 1'b0;
    if (fill_level !== 5'd0) begin n_fail++; $display("FAIL wrap_preset_drain: got %0d want 0", fill_level); end
    n_checks++;
    tick = 1'b1;
    step(); step();
    tick = 1'b0;
    step(); step(); step();
    if (fill_level !== 5'd2) begin n_fail++; $display("FAIL wrap_fill: got %0d want 2", fill_level); end
    n_checks++;
    if (ep_datain !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_marker_7fff: got %h want ffff", ep_datain); end
    n_checks++;
    ep_read = 1'b1;
    step();
    ep_read = 1'b0;
    if (ep_datain !== 16'h8000) begin n_fail++; $display("FAIL wrap_marker_0: got %h want 8000", ep_datain); end
    n_checks++;
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      spike = 1'b1; spike_id = 16'h0200 + 16'(i); tick = (i == 4);
      step();
    end
    spike = 1'b0; tick = 1'b0;
    if (fill_level !== 5'd10) begin n_fail++; $display("FAIL mid_fill_before: got %0d want 10", fill_level); end
    n_checks++;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    if (fill_level !== 5'd0) begin n_fail++; $display("FAIL mid_fill: got %0d want 0", fill_level); end
    n_checks++;
    if (ep_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", ep_ready); end
    n_checks++;
    if (ep_datain !== 16'hFFFF) begin n_fail++; $display("FAIL mid_datain: got %h want ffff", ep_datain); end
    n_checks++;
    step(); step(); step();
    if (fill_level !== 5'd0) begin n_fail++; $display("FAIL mid_pending_cleared: got %0d want 0", fill_level); end
    n_checks++;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step(); step(); step();
    if (fill_level !== 5'd1) begin n_fail++; $display("FAIL mid_post_fill: got %0d want 1", fill_level); end
    n_checks++;
    if (ep_datain !== 16'h8001) begin n_fail++; $display("FAIL mid_post_marker: got %h want 8001", ep_datain); end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_cycle();
    test_enable();
    test_full();
    test_back_to_back();
    test_wrap();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
